// File: rtl/mota_pipe_if.sv
// Handshake and data bundle for mota_pipe: operand-set input channel,
// result output channel and the delivered-result counter.
interface mota_pipe_if #(
    parameter int N = 20,
    parameter int M = 8
);
    localparam int L = $clog2(M);
    localparam int W = N + L;

    // valid/ready: a transfer happens on a rising clk edge where valid && ready;
    // the sender holds its payload stable while valid && !ready.
    logic           in_valid;
    logic           in_ready;
    logic [M*N-1:0] ops;
    logic           sign_en;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   sum;
    logic [15:0]    beat_cnt;

    modport master (
        output in_valid, ops, sign_en, out_ready,
        input  in_ready, out_valid, sum, beat_cnt
    );

    modport slave (
        input  in_valid, ops, sign_en, out_ready,
        output in_ready, out_valid, sum, beat_cnt
    );
endinterface

// File: rtl/mota_pipe.sv
// Pipelined binary adder tree summing M operands of N bits, signed or unsigned
// per beat, one register stage per tree level, with elastic stall handling.
module mota_pipe #(
    parameter int N = 20,
    parameter int M = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    mota_pipe_if.slave  bus
);
    localparam int L = $clog2(M);
    localparam int W = N + L;

    logic         adv;
    logic [L:1]   vld_r;
    logic [L:0]   vld_at;
    logic [L-1:0] sgn_at;
    logic [15:0]  cnt_r;

    // The whole pipe moves together; it only freezes when the output is held.
    assign adv    = !vld_r[L] || bus.out_ready;
    assign vld_at = {vld_r, bus.in_valid};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r <= '0;
        end else if (adv) begin
            vld_r <= vld_at[L-1:0];
        end
    end

    // sgn_at[j-1] is the sign mode seen by the level-j adders; the last
    // stage needs no copy of it, so only L-1 sign registers exist.
    if (L > 1) begin : g_sgn
        logic [L-1:1] sgn_r;

        assign sgn_at = {sgn_r, bus.sign_en};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sgn_r <= '0;
            end else if (adv) begin
                sgn_r <= sgn_at[L-2:0];
            end
        end
    end else begin : g_nosgn
        assign sgn_at = bus.sign_en;
    end

    for (genvar j = 1; j <= L; j++) begin : lvl
        localparam int CNT = M >> j;
        localparam int WI  = N + j - 1;
        localparam int WO  = N + j;

        logic [2*CNT*WI-1:0] src;
        logic [CNT*WO-1:0]   nxt;
        logic [CNT*WO-1:0]   data;

        if (j == 1) begin : g_first
            assign src = bus.ops;
        end else begin : g_next
            assign src = lvl[j-1].data;
        end

        for (genvar k = 0; k < CNT; k++) begin : add
            logic [WI-1:0] a;
            logic [WI-1:0] b;

            assign a = src[2*k*WI +: WI];
            assign b = src[(2*k+1)*WI +: WI];
            // One extra bit per level, filled with the sign bit only in signed mode.
            assign nxt[k*WO +: WO] = {sgn_at[j-1] & a[WI-1], a}
                                   + {sgn_at[j-1] & b[WI-1], b};
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data <= '0;
            end else if (adv) begin
                data <= nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (vld_r[L] && bus.out_ready) begin
            cnt_r <= cnt_r + 16'd1;
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_r[L];
    assign bus.sum       = lvl[L].data;
    assign bus.beat_cnt  = cnt_r;
endmodule

// File: tb/tb_mota_pipe.sv
// Self-checking bench for mota_pipe (N=20, M=8): directed vector table,
// stall / reset / wrap sequences and a scoreboard fed from a sum model.
module tb_mota_pipe;
    localparam int N = 20;
    localparam int M = 8;
    localparam int L = 3;
    localparam int W = N + L;

    typedef struct {
        string          name;
        logic [M*N-1:0] ops;
        logic           sgn;
        logic [W-1:0]   exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [W-1:0] exp_q[$];
    vec_t tbl[7];

    mota_pipe_if #(.N(N), .M(M)) bus ();

    mota_pipe #(.N(N), .M(M)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [M*N-1:0] o, input logic s);
        logic [W-1:0] acc;
        logic [N-1:0] v;
        acc = '0;
        for (int k = 0; k < M; k++) begin
            v = o[k*N +: N];
            acc = acc + (s ? {{L{v[N-1]}}, v} : {{L{1'b0}}, v});
        end
        return acc;
    endfunction

    function automatic logic [M*N-1:0] rnd_ops();
        logic [M*N-1:0] r;
        for (int k = 0; k < M; k++) r[k*N +: N] = N'($urandom);
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.ops, bus.sign_en));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_extra: output 0x%0h with no beat outstanding", bus.sum);
                end else begin
                    check("sb_sum", bus.sum, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [M*N-1:0] o, input logic s, output int cyc);
        bit acc;
        bus.in_valid = 1'b1;
        bus.ops      = o;
        bus.sign_en  = s;
        acc = 1'b0;
        cyc = 0;
        while (!acc && cyc < 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!acc) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: beat not accepted in %0d cycles, want acceptance", cyc);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            if (bus.out_valid) begin
                lat = c;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 50) begin
            @(posedge clk);
            #1;
            c++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- test ----------------
    initial begin
        int t;
        int lat;
        int n_out;
        int n_ov;

        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.ops       = '0;
        bus.sign_en   = 1'b0;
        bus.out_ready = 1'b0;

        tbl[0].name = "t_seq_u";    tbl[0].sgn = 1'b0; tbl[0].exp = 23'h000024;
        tbl[1].name = "t_ones_u";   tbl[1].sgn = 1'b0; tbl[1].exp = 23'h7FFFF8;
        tbl[2].name = "t_ones_s";   tbl[2].sgn = 1'b1; tbl[2].exp = 23'h7FFFF8;
        tbl[3].name = "t_half_s";   tbl[3].sgn = 1'b1; tbl[3].exp = 23'h000000;
        tbl[4].name = "t_half_u";   tbl[4].sgn = 1'b0; tbl[4].exp = 23'h400000;
        tbl[5].name = "t_minneg_s"; tbl[5].sgn = 1'b1; tbl[5].exp = 23'h400000;
        tbl[6].name = "t_zero_u";   tbl[6].sgn = 1'b0; tbl[6].exp = 23'h000000;
        for (int k = 0; k < M; k++) begin
            tbl[0].ops[k*N +: N] = N'(k + 1);
            tbl[1].ops[k*N +: N] = {N{1'b1}};
            tbl[3].ops[k*N +: N] = (k < 4) ? {N{1'b1}} : N'(1);
            tbl[5].ops[k*N +: N] = {1'b1, {(N-1){1'b0}}};
            tbl[6].ops[k*N +: N] = '0;
        end
        tbl[2].ops = tbl[1].ops;
        tbl[4].ops = tbl[3].ops;

        // Reset state, checked while rst_n is still low.
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_sum", bus.sum, 0);
        check("rst_beat_cnt", bus.beat_cnt, 0);
        check("rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 10 back-to-back beats with a 5-cycle output hold mid-stream.
        bus.out_ready = 1'b1;
        fork
            begin
                int ts;
                for (int i = 0; i < 10; i++) send(rnd_ops(), 1'($urandom_range(0, 1)), ts);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                check("stall_out_valid", bus.out_valid, 1);
                for (int c = 0; c < 5; c++) begin
                    @(posedge clk);
                    #1;
                    check("stall_in_ready", bus.in_ready, 0);
                    check("stall_hold_valid", bus.out_valid, 1);
                    check("stall_hold_sum", bus.sum, exp_q[0]);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain("stall_drained");
        check("stall_beat_cnt", bus.beat_cnt, 10);

        // Directed table: latency and exact sum for each vector.
        for (int i = 0; i < 7; i++) begin
            send(tbl[i].ops, tbl[i].sgn, t);
            wait_out(lat);
            check({tbl[i].name, "_lat"}, lat, 3);
            check({tbl[i].name, "_sum"}, bus.sum, tbl[i].exp);
        end
        drain("tbl_drained");

        // Random traffic with bubbles and back-pressure.
        for (int c = 0; c < 60; c++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.ops       = rnd_ops();
            bus.sign_en   = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain("rand_drained");

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) send(rnd_ops(), 1'($urandom_range(0, 1)), t);
        rst_n = 1'b0;
        #1;
        check("mid_out_valid", bus.out_valid, 0);
        check("mid_beat_cnt", bus.beat_cnt, 0);
        check("mid_in_ready", bus.in_ready, 1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(tbl[0].ops, 1'b0, t);
        check("post_rst_accept_cycles", t, 1);
        n_out = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.out_valid) n_out++;
            @(posedge clk);
            #1;
        end
        check("post_rst_outputs", n_out, 1);
        check("post_rst_beat_cnt", bus.beat_cnt, 1);
        drain("post_rst_drained");

        // Continuous streaming of 65537 beats: throughput and counter wrap.
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        n_ov = 0;
        for (int i = 0; i < 65537; i++) begin
            bus.ops     = rnd_ops();
            bus.sign_en = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            if (bus.out_valid) n_ov++;
        end
        bus.in_valid = 1'b0;
        check("stream_valid_cycles", n_ov, 65535);
        repeat (5) @(posedge clk);
        #1;
        check("wrap_beat_cnt", bus.beat_cnt, 1);
        check("wrap_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mota_pipe.md
MOTA_PIPE -- requirements
Module: mota_pipe

Interface
REQ-001 SHALL have parameter N, default 20: operand width in bits, legal range 2..64.
REQ-002 SHALL have parameter M, default 8: operand count, a power of two, legal range 2..16.
REQ-003 SHALL define derived constant L = log2(M) as the tree depth and pipeline latency, and W = N+L as the result width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: an operand set is presented.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts the set this cycle.
REQ-008 SHALL have port ops, input, M*N bits: operand k occupies ops[k*N +: N].
REQ-009 SHALL have port sign_en, input, 1 bit: 1 means the beat's operands are two's-complement, 0 means unsigned; captured with the beat.
REQ-010 SHALL have port out_valid, output, 1 bit: sum holds a completed result.
REQ-011 SHALL have port out_ready, input, 1 bit: the downstream consumer takes the result.
REQ-012 SHALL have port sum, output, W bits: the full-precision sum of the M operands.
REQ-013 SHALL have port beat_cnt, output, 16 bits: count of results delivered, i.e. handshakes with out_valid&&out_ready.

Function
REQ-014 SHALL implement a binary adder tree of L levels with a register stage after every level, with each register stage carrying a valid bit and the beat's sign_en.
REQ-015 SHALL widen level j adders (j=1..L) to N+j bits, each operand extended by zero-extension when sign_en=0 and by sign-extension when sign_en=1, with no truncation at any level.
REQ-016 SHALL accept a beat when in_valid&&in_ready, and SHALL ignore ops and sign_en in every other cycle.
REQ-017 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-018 SHALL, when in_ready=0, freeze every pipeline stage (data and valid) and hold sum and out_valid stable until out_ready=1.
REQ-019 SHALL, when in_ready=1, advance all stages by one each cycle, loading stage 1's valid bit with in_valid.
REQ-020 SHALL have a latency of exactly L cycles from acceptance to out_valid=1 when there is no stall.
REQ-021 SHALL sustain a throughput of one result per cycle when in_valid=1 and out_ready=1 continuously, with a simultaneous accept and drain in the same cycle legal and lossless.
REQ-022 SHALL propagate bubbles (invalid stages) unchanged, without compressing them, and SHALL drive out_valid=0 for them.
REQ-023 SHALL deliver results in acceptance order, with no drop and no duplicate.
REQ-024 SHALL leave the value of sum a don't-care when out_valid=0, and verification SHALL NOT check it then.
REQ-025 SHALL increment beat_cnt by 1 per output handshake and SHALL wrap it from 0xFFFF to 0x0000.

Reset
REQ-026 SHALL, while rst_n=0, immediately force all stage valid bits to 0, out_valid=0, sum=0 and beat_cnt=0, independent of clk.
REQ-027 SHALL drive in_ready=1 during and after reset, as a consequence of out_valid=0.
REQ-028 SHALL, when reset is asserted mid-operation, discard every in-flight beat, with no result from a beat accepted before reset ever appearing.
REQ-029 SHALL accept a new beat on the first rising clk edge after rst_n deasserts.

Verification
REQ-030 SHALL cover this directed scenario (N=20, M=8): unsigned ops 1,2,...,8, out_ready=1 -> out_valid high exactly 3 cycles after acceptance, sum=0x000024.
REQ-031 SHALL cover this directed scenario: all ops 0xFFFFF, sign_en=0 -> sum=0x7FFFF8; the same ops with sign_en=1 -> sum=0x7FFFF8 (-8).
REQ-032 SHALL cover this directed scenario: ops 0xFFFFF x4 plus 0x00001 x4, sign_en=1 -> sum=0x000000; the same with sign_en=0 -> sum=0x400000.
REQ-033 SHALL cover this directed scenario: 10 back-to-back beats, out_ready held 0 for 5 cycles mid-stream -> in_ready=0 during the hold, sum and out_valid stable, all 10 results in order, beat_cnt=10.
REQ-034 SHALL cover this directed scenario: rst_n pulsed low with 3 beats in flight -> out_valid=0 and beat_cnt=0 immediately, and none of the 3 results ever emerges.
REQ-035 SHALL cover this directed scenario: 65537 drained beats -> beat_cnt=0x0001 (wrap).
